isp_csc_cfg_sched: RTL and testbench



---
 rtl/isp_csc_cfg_sched_if.sv | 19 +
 rtl/isp_csc_cfg_sched.sv | 181 ++++++++++++++++++
 tb/tb_isp_csc_cfg_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isp_csc_cfg_sched_if.sv
// Configuration request channel between the register side (master) and the
// CSC configuration scheduler (slave): valid/ready with a 2-bit standard.
interface isp_csc_cfg_sched_if;
  logic       cfg_valid;
  logic [1:0] cfg_conv_standard;
  logic       cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_conv_standard,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_conv_standard,
    output cfg_ready
  );
endinterface

// File: rtl/isp_csc_cfg_sched.sv
// isp_csc_cfg_sched: frame-synchronous configuration scheduler for the CSC
// stage. Buffers one conversion-standard update and commits it only between
// frames once the CSC pipeline has drained. Counts frames.
// Optional geometry checking (line/pixel counters, geom_err, err_sticky) is
// built when ISP_CSC_CFG_GEOM_CHK_EN is defined; otherwise those outputs are 0.
module isp_csc_cfg_sched #(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned HEIGHT    = 960,
  parameter int unsigned DRAIN_CYC = 9
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                in_href,
  input  logic                in_vsync,
  isp_csc_cfg_sched_if.slave  cfg,
  input  logic                err_clr,
  output logic [1:0]          csc_conv_standard,
  output logic                commit,
  output logic [15:0]         frame_cnt,
  output logic                frame_done,
  output logic                geom_err,
  output logic                err_sticky
);

  localparam int unsigned DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_FRAME = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           pending_q, pending_d;
  logic [1:0]     shadow_q, shadow_d;
  logic [1:0]     csc_q, csc_d;
  logic           commit_q, commit_d;
  logic           ready_q, ready_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_start, frame_end;
  logic           accept, commit_en;

  // Next-state: frame FSM, handshake/shadow, commit gating, drain timer, frame count
  always_comb begin
    state_d      = state_q;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    csc_d        = csc_q;

    unique case (state_q)
      S_IDLE:  if (in_vsync) state_d = S_SYNC;
      S_SYNC:  if (!in_vsync) begin
                 state_d     = S_FRAME;
                 frame_start = 1'b1;
               end
      S_FRAME: if (in_vsync) begin
                 state_d   = S_SYNC;
                 frame_end = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase

    // accept needs ready_q (= !pending_q) and commit needs pending_q, so they never coincide
    accept    = cfg.cfg_valid && ready_q;
    commit_en = pending_q && (state_q != S_FRAME) && (drain_q == '0) && !in_href;

    if (accept) begin
      pending_d = 1'b1;
      shadow_d  = cfg.cfg_conv_standard;
    end else if (commit_en) begin
      pending_d = 1'b0;
      csc_d     = shadow_q;
    end

    ready_d      = !pending_d;
    commit_d     = commit_en;
    drain_d      = in_href ? DRAIN_LD : ((drain_q == '0) ? '0 : drain_q - 1'b1);
    frame_cnt_d  = frame_start ? frame_cnt_q + 1'b1 : frame_cnt_q;
    frame_done_d = frame_end;
  end

  // State and control registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      csc_q        <= '0;
      commit_q     <= 1'b0;
      ready_q      <= 1'b1;
      drain_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      csc_q        <= csc_d;
      commit_q     <= commit_d;
      ready_q      <= ready_d;
      drain_q      <= drain_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cfg.cfg_ready         = ready_q;
  assign csc_conv_standard     = csc_q;
  assign commit                = commit_q;
  assign frame_cnt             = frame_cnt_q;
  assign frame_done            = frame_done_q;

`ifdef ISP_CSC_CFG_GEOM_CHK_EN
  localparam logic [15:0] PX_W = 16'(WIDTH);
  localparam logic [15:0] LN_H = 16'(HEIGHT);

  logic [15:0] px_cnt_q, px_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        bad_q, bad_d, bad_now;
  logic        href_q;
  logic        geom_err_q, geom_err_d;
  logic        err_sticky_q, err_sticky_d;

  // Geometry next-state; a short line ending on the vsync edge itself must
  // still flag the frame, so the end-of-frame check uses bad_now, not bad_q
  always_comb begin
    px_cnt_d   = px_cnt_q;
    line_cnt_d = line_cnt_q;
    bad_now    = bad_q;
    if (state_q == S_FRAME) begin
      if (in_href && (px_cnt_q != '1)) px_cnt_d = px_cnt_q + 1'b1;
      if (in_href && !href_q && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 1'b1;
      if (!in_href && href_q) begin
        if (px_cnt_q != PX_W) bad_now = 1'b1;
        px_cnt_d = '0;
      end
    end
    bad_d = bad_now;
    if (frame_start) begin
      px_cnt_d   = '0;
      line_cnt_d = '0;
      bad_d      = 1'b0;
    end
    geom_err_d   = frame_end && (bad_now || (line_cnt_q != LN_H) || in_href);
    err_sticky_d = geom_err_d ? 1'b1 : (err_clr ? 1'b0 : err_sticky_q);
  end

  // Geometry registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt_q     <= '0;
      line_cnt_q   <= '0;
      bad_q        <= 1'b0;
      href_q       <= 1'b0;
      geom_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      px_cnt_q     <= px_cnt_d;
      line_cnt_q   <= line_cnt_d;
      bad_q        <= bad_d;
      href_q       <= in_href;
      geom_err_q   <= geom_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign geom_err   = geom_err_q;
  assign err_sticky = err_sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign geom_err       = 1'b0;
  assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_isp_csc_cfg_sched.sv
// Self-checking bench for isp_csc_cfg_sched (WIDTH=8, HEIGHT=4, DRAIN_CYC=9).
// A frame-level reference model predicts every registered output each cycle.
module tb_isp_csc_cfg_sched;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned HEIGHT    = 4;
  localparam int unsigned DRAIN_CYC = 9;
`ifdef ISP_CSC_CFG_GEOM_CHK_EN
  localparam bit GEOM = 1'b1;
`else
  localparam bit GEOM = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_href = 1'b0;
  logic        in_vsync = 1'b0;
  logic        err_clr = 1'b0;
  logic [1:0]  csc_conv_standard;
  logic        commit;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic        geom_err;
  logic        err_sticky;

  isp_csc_cfg_sched_if cfg_if ();

  isp_csc_cfg_sched #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .pclk              (pclk),
    .rst_n             (rst_n),
    .in_href           (in_href),
    .in_vsync          (in_vsync),
    .cfg               (cfg_if),
    .err_clr           (err_clr),
    .csc_conv_standard (csc_conv_standard),
    .commit            (commit),
    .frame_cnt         (frame_cnt),
    .frame_done        (frame_done),
    .geom_err          (geom_err),
    .err_sticky        (err_sticky)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit          m_ready, m_pending, m_commit, m_fdone, m_geom, m_sticky;
  bit          m_in_frame, m_sync_seen, m_prev_href;
  logic [1:0]  m_shadow, m_csc;
  logic [15:0] m_fcnt;
  int          m_cyc, m_last_href;
  int          lines[$];

  typedef struct packed {
    logic       href;
    logic       vs;
    logic       valid;
    logic [1:0] std;
    logic       clr;
  } stim_t;

  stim_t sq[$];
  int    last_href_idx, vs_rise_idx, offer_idx;

  localparam logic [22:0] RST_VEC = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

  task automatic model_reset();
    m_ready = 1'b1; m_pending = 1'b0; m_commit = 1'b0; m_fdone = 1'b0;
    m_geom = 1'b0; m_sticky = 1'b0; m_in_frame = 1'b0; m_sync_seen = 1'b0;
    m_prev_href = 1'b0; m_shadow = 2'b00; m_csc = 2'b00; m_fcnt = 16'h0;
    m_cyc = 0; m_last_href = -100;
    lines.delete();
  endtask

  // One rising edge of the model, fed the inputs the DUT samples at that edge.
  task automatic model_edge(input stim_t s);
    bit accept, do_commit, frame_end, frame_start, bad;
    accept      = s.valid && m_ready;
    do_commit   = m_pending && !m_in_frame && !s.href && ((m_cyc - m_last_href) > int'(DRAIN_CYC));
    frame_end   = m_in_frame && s.vs;
    frame_start = !m_in_frame && m_sync_seen && !s.vs;
    if (m_in_frame && s.href) begin
      if (!m_prev_href || lines.size() == 0) lines.push_back(1);
      else lines[lines.size()-1] += 1;
    end
    bad = s.href || (lines.size() != int'(HEIGHT));
    foreach (lines[k]) if (lines[k] != int'(WIDTH)) bad = 1'b1;
    if (do_commit) begin
      m_pending = 1'b0;
      m_csc     = m_shadow;
    end
    if (accept) begin
      m_pending = 1'b1;
      m_shadow  = s.std;
    end
    m_commit = do_commit;
    m_ready  = !m_pending;
    if (s.href) m_last_href = m_cyc;
    m_fdone = frame_end;
    m_geom  = GEOM && frame_end && bad;
    if (GEOM) m_sticky = m_geom ? 1'b1 : (s.clr ? 1'b0 : m_sticky);
    if (frame_start) begin
      m_in_frame = 1'b1;
      m_fcnt     = m_fcnt + 16'd1;
      lines.delete();
    end
    if (frame_end) m_in_frame = 1'b0;
    if (s.vs) m_sync_seen = 1'b1;
    m_prev_href = s.href;
    m_cyc++;
  endtask

  function automatic logic [22:0] exp_vec();
    return {m_ready, m_csc, m_commit, m_fdone, m_geom, m_sticky, m_fcnt};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {cfg_if.cfg_ready, csc_conv_standard, commit, frame_done, geom_err, err_sticky, frame_cnt};
  endfunction

  // Drive one cycle of stimulus, advance the model on the edge, settle 1 time unit.
  task automatic tick(input stim_t s);
    in_href = s.href;
    in_vsync = s.vs;
    cfg_if.cfg_valid = s.valid;
    cfg_if.cfg_conv_standard = s.std;
    err_clr = s.clr;
    @(posedge pclk);
    model_edge(s);
    #1;
  endtask

  function automatic stim_t mk(input logic href, input logic vs, input logic valid,
                               input logic [1:0] std, input logic clr);
    stim_t s;
    s.href = href; s.vs = vs; s.valid = valid; s.std = std; s.clr = clr;
    return s;
  endfunction

  // Appends: 2 sync cycles, front porch, lines, tail, then sync_len sync cycles.
  task automatic build_frame(input int nlines, input int short_line, input int tail,
                             input int sync_len, input int offer_line, input logic [1:0] offer_std);
    int len;
    offer_idx = -1;
    repeat (2) sq.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
    repeat (2) sq.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? int'(WIDTH) - 1 : int'(WIDTH);
      for (int p = 0; p < len; p++) begin
        if (l == offer_line && p == 0) offer_idx = sq.size();
        sq.push_back(mk(1'b1, 1'b0, (l == offer_line && p == 0), offer_std, 1'b0));
      end
      if (l != nlines - 1) repeat ($urandom_range(1, 4)) sq.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    end
    last_href_idx = sq.size() - 1;
    repeat (tail) sq.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    vs_rise_idx = sq.size();
    repeat (sync_len) sq.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_conv_standard = 2'b00;
    model_reset();
    #22;
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_values: got %h want %h", dut_vec(), RST_VEC);
    end
    @(negedge pclk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_commit();
    tick(mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b0));
    n_cmp++;
    if ({cfg_if.cfg_ready, commit, csc_conv_standard} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_accept: rdy/cmt/csc got %b want 0000", {cfg_if.cfg_ready, commit, csc_conv_standard});
    end
    tick(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    n_cmp++;
    if ({cfg_if.cfg_ready, commit, csc_conv_standard} !== 4'b1101) begin
      n_err++;
      $display("FAIL idle_commit: rdy/cmt/csc got %b want 1101", {cfg_if.cfg_ready, commit, csc_conv_standard});
    end
    tick(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    n_cmp++;
    if ({cfg_if.cfg_ready, commit, csc_conv_standard} !== 4'b1001) begin
      n_err++;
      $display("FAIL idle_after: rdy/cmt/csc got %b want 1001", {cfg_if.cfg_ready, commit, csc_conv_standard});
    end
  endtask

  task automatic test_back_to_back();
    int ncommit = 0;
    for (int i = 0; i < 12; i++) begin
      tick(mk(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b cyc %0d: {rdy,csc,cmt,fd,ge,es,fcnt} got %h want %h", i, dut_vec(), exp_vec());
      end
      if (commit === 1'b1) ncommit++;
    end
    n_cmp++;
    if (ncommit != 6) begin
      n_err++;
      $display("FAIL b2b_commit_count: got %0d want 6", ncommit);
    end
  endtask

  task automatic test_frame_ok();
    int nfd = 0, nge = 0;
    logic [15:0] exp_fc;
    exp_fc = m_fcnt + 16'd1;
    sq.delete();
    build_frame(4, -1, 4, 14, -1, 2'b00);
    for (int i = 0; i < sq.size(); i++) begin
      tick(sq[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL frame_ok cyc %0d: {rdy,csc,cmt,fd,ge,es,fcnt} got %h want %h", i, dut_vec(), exp_vec());
      end
      if (frame_done === 1'b1) nfd++;
      if (geom_err === 1'b1) nge++;
    end
    n_cmp++;
    if (nfd != 1 || nge != 0) begin
      n_err++;
      $display("FAIL frame_ok_pulses: frame_done %0d geom_err %0d want 1 0", nfd, nge);
    end
    n_cmp++;
    if (frame_cnt !== exp_fc) begin
      n_err++;
      $display("FAIL frame_ok_cnt: got %0d want %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_midframe_update();
    int tails[2] = '{3, 12};
    for (int r = 0; r < 2; r++) begin
      int ncommit = 0, cidx = -1, exp_idx;
      sq.delete();
      build_frame(4, -1, tails[r], 16, 1, 2'($urandom_range(0, 3)));
      exp_idx = last_href_idx + int'(DRAIN_CYC) + 1;
      if (vs_rise_idx + 1 > exp_idx) exp_idx = vs_rise_idx + 1;
      for (int i = 0; i < sq.size(); i++) begin
        tick(sq[i]);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL midframe r%0d cyc %0d: {rdy,csc,cmt,fd,ge,es,fcnt} got %h want %h", r, i, dut_vec(), exp_vec());
        end
        if (commit === 1'b1) begin
          ncommit++;
          cidx = i;
        end
      end
      n_cmp++;
      if (ncommit != 1 || cidx != exp_idx) begin
        n_err++;
        $display("FAIL midframe_commit r%0d: count %0d at %0d want 1 at %0d", r, ncommit, cidx, exp_idx);
      end
    end
  endtask

  task automatic test_geom_err();
    for (int r = 0; r < 2; r++) begin
      int nge = 0;
      sq.delete();
      if (r == 0) build_frame(4, 2, 4, 6, -1, 2'b00);
      else begin
        build_frame(5, -1, 4, 6, -1, 2'b00);
        sq[vs_rise_idx].clr = 1'b1;
      end
      for (int i = 0; i < sq.size(); i++) begin
        tick(sq[i]);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL geom r%0d cyc %0d: {rdy,csc,cmt,fd,ge,es,fcnt} got %h want %h", r, i, dut_vec(), exp_vec());
        end
        if (geom_err === 1'b1) nge++;
      end
      n_cmp++;
      if (nge != int'(GEOM) || err_sticky !== GEOM) begin
        n_err++;
        $display("FAIL geom_pulse r%0d: pulses %0d sticky %b want %0d %b", r, nge, err_sticky, GEOM, GEOM);
      end
    end
    tick(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1));
    n_cmp++;
    if (err_sticky !== 1'b0 || err_sticky !== m_sticky) begin
      n_err++;
      $display("FAIL geom_clear: sticky got %b want 0", err_sticky);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int nl, sl;
      sq.delete();
      nl = ($urandom_range(0, 3) == 0) ? 5 : 4;
      sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      build_frame(nl, sl, $urandom_range(0, 12), 6, $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      if (f == 3) repeat (12) sq.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
      for (int i = 0; i < sq.size(); i++) begin
        if ($urandom_range(0, 7) == 0) begin
          sq[i].valid = 1'b1;
          sq[i].std   = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 15) == 0) sq[i].clr = 1'b1;
      end
      for (int i = 0; i < sq.size(); i++) begin
        tick(sq[i]);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL random f%0d cyc %0d: {rdy,csc,cmt,fd,ge,es,fcnt} got %h want %h", f, i, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int ncommit = 0;
    sq.delete();
    build_frame(4, -1, 4, 6, 1, 2'b01);
    for (int i = 0; i <= offer_idx + 3; i++) begin
      tick(sq[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rstmid cyc %0d: {rdy,csc,cmt,fd,ge,es,fcnt} got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_pending: cfg_ready got %b want 0", cfg_if.cfg_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL rstmid_async: got %h want %h", dut_vec(), RST_VEC);
    end
    model_reset();
    @(negedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rstmid_after cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (commit === 1'b1) ncommit++;
    end
    n_cmp++;
    if (ncommit != 0 || csc_conv_standard !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_discard: commits %0d csc %b want 0 00", ncommit, csc_conv_standard);
    end
  endtask

  initial begin
    test_reset();
    test_idle_commit();
    test_back_to_back();
    test_frame_ok();
    test_midframe_update();
    test_geom_err();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
